cic_decim_sequencer: RTL

//  Control sequencer for the CIC decimation chain (integrators -> decimation counter -> combs).

---
 rtl/cic_pkg.sv | 14 +
 rtl/cic_decim_sequencer.sv | 105 ++++++++++
 2 files changed

// File: rtl/cic_pkg.sv
// Shared types and width helpers for the CIC decimation chain sequencer and datapath.
package cic_pkg;

   typedef enum logic [1:0] {IDLE, START, SETTLE, RUN} cic_seq_state_t;

   function automatic int cic_rate_w(input int r_max);
      return $clog2(r_max + 1);
   endfunction

   function automatic int cic_ph_w(input int r_max);
      return (r_max <= 1) ? 1 : $clog2(r_max);
   endfunction

endpackage

// File: rtl/cic_decim_sequencer.sv
// Sequences the CIC chain: integrator/comb enables, clear pulse, settle gating and ratio changes.
// Enables are zero-latency from s_axis_in_tvalid; a new ratio is only taken on a decimation boundary or in IDLE.
module cic_decim_sequencer
   import cic_pkg::*;
#(
   parameter int CIC_R_MAX    = 64,
   parameter int CIC_N        = 4,
   parameter int RATE_DEFAULT = 4,
   localparam int RATE_W      = cic_rate_w(CIC_R_MAX),
   localparam int PH_W        = cic_ph_w(CIC_R_MAX)
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              en,
   input  logic              s_axis_in_tvalid,
   input  logic [RATE_W-1:0] cfg_rate,
   input  logic              cfg_valid,
   output logic              cfg_ready,
   output logic              int_ce,
   output logic              int_clr,
   output logic              comb_ce,
   output logic              out_gate,
   output logic [PH_W-1:0]   phase,
   output logic [RATE_W-1:0] rate
);

   localparam int SET_W = $clog2(CIC_N + 1);

   cic_seq_state_t    state_q;
   logic [PH_W-1:0]   phase_q;
   logic [RATE_W-1:0] rate_q;
   logic [SET_W-1:0]  settle_q;

   logic              running;
   logic              last_ph;
   logic              cfg_fire;
   logic [RATE_W-1:0] rate_d;

   function automatic logic [RATE_W-1:0] clamp_rate(input logic [RATE_W-1:0] r);
      if (r == '0)
         return RATE_W'(1);
      else if (r > RATE_W'(CIC_R_MAX))
         return RATE_W'(CIC_R_MAX);
      return r;
   endfunction

   assign running   = (state_q == SETTLE) || (state_q == RUN);
   assign last_ph   = (RATE_W'(phase_q) == (rate_q - RATE_W'(1)));
   assign int_ce    = s_axis_in_tvalid & running;
   assign comb_ce   = int_ce & last_ph;
   // Ratio may only change where a decimation period ends, so the combs never see a torn period.
   assign cfg_ready = (state_q == IDLE) | comb_ce;
   assign cfg_fire  = cfg_valid & cfg_ready;
   assign rate_d    = clamp_rate(cfg_rate);

   assign int_clr   = (state_q == START);
   assign out_gate  = (state_q == RUN);
   assign phase     = phase_q;
   assign rate      = rate_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= IDLE;
         phase_q  <= '0;
         rate_q   <= RATE_W'(RATE_DEFAULT);
         settle_q <= '0;
      end else begin
         if (cfg_fire)
            rate_q <= rate_d;

         if (!en) begin
            state_q  <= IDLE;
            phase_q  <= '0;
            settle_q <= '0;
         end else begin
            case (state_q)
               IDLE: begin
                  phase_q <= '0;
                  if (!cfg_fire)
                     state_q <= START;
               end
               START: begin
                  phase_q  <= '0;
                  settle_q <= '0;
                  state_q  <= SETTLE;
               end
               SETTLE, RUN: begin
                  if (int_ce)
                     phase_q <= last_ph ? '0 : phase_q + PH_W'(1);
                  // A rate change on the settling boundary restarts rather than completing settle.
                  if (cfg_fire) begin
                     state_q <= START;
                  end else if ((state_q == SETTLE) && comb_ce) begin
                     settle_q <= settle_q + SET_W'(1);
                     if (settle_q == SET_W'(CIC_N - 1))
                        state_q <= RUN;
                  end
               end
               default: state_q <= IDLE;
            endcase
         end
      end
   end

endmodule
